key_click_decoder: RTL and testbench

- Consumes the one-cycle debounced press pulse from the key debouncer and groups presses into click gestures.
- Classifies single, double and triple clicks using a programmable inter-click window.
- Emits one-cycle event pulses to the downstream mode/menu control logic.
- Sits directly after the debouncer, one instance per key, in the same clock domain.

---
 rtl/key_click_decoder.sv | 108 ++++++++++
 tb/tb_key_click_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// Groups debounced key presses into single/double/triple click gestures
// using a programmable inter-click window; emits one-cycle event pulses.
module key_click_decoder #(
    parameter int WIN_CYCLES = 15_000_000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click,
    output logic [1:0] click_cnt,
    output logic [1:0] last_event,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(WIN_CYCLES - 1);

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] timer_reg,  timer_next;
    logic [1:0]       cnt_reg,    cnt_next;
    logic [1:0]       last_reg,   last_next;
    logic             single_reg, single_next;
    logic             double_reg, double_next;
    logic             triple_reg, triple_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            cnt_reg    <= 2'd0;
            last_reg   <= 2'd0;
            single_reg <= 1'b0;
            double_reg <= 1'b0;
            triple_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            cnt_reg    <= cnt_next;
            last_reg   <= last_next;
            single_reg <= single_next;
            double_reg <= double_next;
            triple_reg <= triple_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        cnt_next    = cnt_reg;
        last_next   = last_reg;
        single_next = 1'b0;
        double_next = 1'b0;
        triple_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (key_flag) begin
                    state_next = WAIT;
                    cnt_next   = 2'd1;
                    timer_next = '0;
                end
            end
            WAIT: begin
                // A press always beats a simultaneous window expiry.
                if (key_flag) begin
                    timer_next = '0;
                    if (cnt_reg == 2'd2) begin
                        triple_next = 1'b1;
                        last_next   = 2'd3;
                        cnt_next    = 2'd0;
                        state_next  = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    single_next = (cnt_reg == 2'd1);
                    double_next = (cnt_reg == 2'd2);
                    last_next   = cnt_reg;
                    cnt_next    = 2'd0;
                    timer_next  = '0;
                    state_next  = IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
                timer_next = '0;
            end
        endcase
    end

    assign single_click = single_reg;
    assign double_click = double_reg;
    assign triple_click = triple_reg;
    assign click_cnt    = cnt_reg;
    assign last_event   = last_reg;
    assign busy         = (state_reg == WAIT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder: directed gesture scenarios plus randomized
// press trains, checked cycle by cycle against a deadline-based gesture model.
module tb_key_click_decoder;

    localparam int WIN = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_flag = 1'b0;
    logic       single_click, double_click, triple_click, busy;
    logic [1:0] click_cnt, last_event;

    int total = 0;
    int bad   = 0;

    // Gesture model: an open gesture has a press count and an absolute
    // deadline cycle; no press by the deadline closes it with its count.
    bit m_open = 1'b0;
    int m_cnt  = 0;
    int m_last = 0;
    int m_ev   = 0;
    int m_cyc  = 0;
    int m_dl   = 0;

    key_click_decoder #(.WIN_CYCLES(WIN), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .key_flag(key_flag),
        .single_click(single_click), .double_click(double_click),
        .triple_click(triple_click), .click_cnt(click_cnt),
        .last_event(last_event), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {single_click, double_click, triple_click, click_cnt, last_event, busy};
    endfunction

    function automatic logic [7:0] expv();
        return {m_ev == 1, m_ev == 2, m_ev == 3, 2'(m_cnt), 2'(m_last), m_open};
    endfunction

    task automatic model_step(input bit k);
        m_ev = 0;
        if (k) begin
            if (m_open && m_cnt == 2) begin
                m_ev = 3; m_last = 3; m_open = 0; m_cnt = 0;
            end else if (m_open) begin
                m_cnt = m_cnt + 1; m_dl = m_cyc + WIN;
            end else begin
                m_open = 1; m_cnt = 1; m_dl = m_cyc + WIN;
            end
        end else if (m_open && m_cyc == m_dl) begin
            m_ev = m_cnt; m_last = m_cnt; m_open = 0; m_cnt = 0;
        end
        m_cyc = m_cyc + 1;
    endtask

    // Drives one cycle's key_flag, advances past the edge and the model.
    task automatic drive_cycle(input bit k);
        key_flag = k;
        @(posedge clk);
        #1;
        model_step(k);
        key_flag = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (obs() !== 8'h00) begin
            bad++; $display("FAIL reset_state: got %b want %b", obs(), 8'h00);
        end
        rst = 1'b0;
        drive_cycle(1'b0);
        total++;
        if (obs() !== 8'h00) begin
            bad++; $display("FAIL post_reset_idle: got %b want %b", obs(), 8'h00);
        end
    endtask

    task automatic test_single();
        int first = -1, n = 0;
        for (int t = 0; t < 45; t++) begin
            drive_cycle(t == 10);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL single_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (single_click) begin n++; if (first < 0) first = t + 1; end
            if (t + 1 == 31) begin
                total++;
                if (busy !== 1'b0 || last_event !== 2'd1) begin
                    bad++; $display("FAIL single_c31: got busy=%b last=%0d want busy=0 last=1", busy, last_event);
                end
            end
        end
        total++;
        if (first != 31 || n != 1) begin
            bad++; $display("FAIL single_pulse: got first=%0d count=%0d want 31/1", first, n);
        end
    endtask

    task automatic test_double();
        int first = -1;
        for (int t = 0; t < 55; t++) begin
            drive_cycle(t == 10 || t == 25);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL double_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (double_click && first < 0) first = t + 1;
            if (t + 1 == 26) begin
                total++;
                if (click_cnt !== 2'd2) begin
                    bad++; $display("FAIL double_cnt_c26: got %0d want 2", click_cnt);
                end
            end
        end
        total++;
        if (first != 46 || last_event !== 2'd2) begin
            bad++; $display("FAIL double_pulse: got first=%0d last=%0d want 46/2", first, last_event);
        end
    endtask

    task automatic test_triple();
        int first = -1, other = 0;
        for (int t = 0; t < 70; t++) begin
            drive_cycle(t == 10 || t == 20 || t == 30);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL triple_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (triple_click && first < 0) first = t + 1;
            if (single_click || double_click) other++;
            if (t + 1 == 31) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL triple_busy_c31: got %b want 0", busy);
                end
            end
        end
        total++;
        if (first != 31 || other != 0 || last_event !== 2'd3) begin
            bad++; $display("FAIL triple_pulse: got first=%0d other=%0d last=%0d want 31/0/3", first, other, last_event);
        end
    endtask

    task automatic test_collision();
        int first = -1, singles = 0;
        for (int t = 0; t < 60; t++) begin
            drive_cycle(t == 10 || t == 30);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL collide_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (double_click && first < 0) first = t + 1;
            if (single_click) singles++;
        end
        total++;
        if (first != 51 || singles != 0) begin
            bad++; $display("FAIL collide_pulse: got double=%0d singles=%0d want 51/0", first, singles);
        end
    endtask

    task automatic test_boundary();
        int first = -1;
        for (int t = 0; t < 60; t++) begin
            drive_cycle(t == 10 || t == 31);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL boundary_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (single_click && first < 0) first = t + 1;
            if (t + 1 == 32) begin
                total++;
                if (click_cnt !== 2'd1 || busy !== 1'b1) begin
                    bad++; $display("FAIL boundary_c32: got cnt=%0d busy=%b want 1/1", click_cnt, busy);
                end
            end
        end
        total++;
        if (first != 31) begin
            bad++; $display("FAIL boundary_pulse: got single=%0d want 31", first);
        end
    endtask

    task automatic test_back_to_back();
        int ft = -1, fs = -1;
        for (int t = 0; t < 45; t++) begin
            drive_cycle(t == 10 || t == 12 || t == 14 || t == 15);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL b2b_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (triple_click && ft < 0) ft = t + 1;
            if (single_click && fs < 0) fs = t + 1;
        end
        total++;
        if (ft != 15 || fs != 36 || last_event !== 2'd1) begin
            bad++; $display("FAIL b2b_pulse: got triple=%0d single=%0d last=%0d want 15/36/1", ft, fs, last_event);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int t = 0; t < 20; t++) begin
            drive_cycle(t == 10 || t == 15);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL rstmid_seq c%0d: got %b want %b", t + 1, obs(), expv());
            end
        end
        rst = 1'b1;
        m_open = 0; m_cnt = 0; m_last = 0; m_ev = 0;
        #1;
        total++;
        if (obs() !== 8'h00) begin
            bad++; $display("FAIL rstmid_async: got %b want %b", obs(), 8'h00);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        m_cyc = m_cyc + 2;
        total++;
        if (obs() !== 8'h00) begin
            bad++; $display("FAIL rstmid_held: got %b want %b", obs(), 8'h00);
        end
        rst = 1'b0;
        for (int t = 22; t < 60; t++) begin
            drive_cycle(1'b0);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL rstmid_after c%0d: got %b want %b", t + 1, obs(), expv());
            end
            if (single_click || double_click || triple_click) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL rstmid_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_random();
        int gap = 5, prints = 0, r;
        for (int t = 0; t < 4000; t++) begin
            gap--;
            if (gap == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 2)       gap = WIN;
                else if (r == 2) gap = WIN + 1;
                else             gap = int'($urandom_range(2, 30));
                drive_cycle(1'b1);
            end else begin
                drive_cycle(1'b0);
            end
            total++;
            if (obs() !== expv()) begin
                bad++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random_seq step %0d: got %b want %b", t, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_triple();
        test_collision();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
